// File: rtl/sr_latch_monitor.sv
// Clocked response checker for an SR NOR latch: tracks the expected latch state, waits out a
// settle window after every S/R change, then flags and counts output errors. Optional coverage counters: SR_MON_COVER_EN.
module sr_latch_monitor #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             q_bar,
    input  logic             clr_err,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             err_mismatch,
    output logic             err_compl,
    output logic             err_forbid,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
`ifdef SR_MON_COVER_EN
    ,
    output logic [CNT_W-1:0] cov_set,
    output logic [CNT_W-1:0] cov_reset,
    output logic [CNT_W-1:0] cov_hold,
    output logic [CNT_W-1:0] cov_forbid
`endif
);

    localparam logic [1:0] ST_UNKNOWN = 2'd0;
    localparam logic [1:0] ST_SET     = 2'd1;
    localparam logic [1:0] ST_RESET   = 2'd2;
    localparam logic [1:0] ST_FORBID  = 2'd3;

    localparam int               SUM_W       = CNT_W + 2;
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       sr;
    logic [1:0]       prev_sr;
    logic [3:0]       settle_cnt;
    logic             exp_q_nxt;
    logic             mismatch_nxt;
    logic             compl_nxt;
    logic             forbid_nxt;
    logic [1:0]       n_err;
    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] cnt_nxt;

    assign sr        = {s, r};
    assign exp_valid = (settle_cnt == '0) && (state != ST_UNKNOWN);

    always_comb begin
        state_nxt = state;
        case (sr)
            2'b10:   state_nxt = ST_SET;
            2'b01:   state_nxt = ST_RESET;
            2'b11:   state_nxt = ST_FORBID;
            default: begin
                // Leaving s=r=1 is a race in a real latch: the outcome is indeterminate.
                if (state == ST_FORBID)
                    state_nxt = ST_UNKNOWN;
            end
        endcase
    end

    always_comb begin
        exp_q_nxt = exp_q;
        case (state_nxt)
            ST_SET:    exp_q_nxt = 1'b1;
            ST_RESET:  exp_q_nxt = 1'b0;
            ST_FORBID: exp_q_nxt = 1'b0;
            default:   exp_q_nxt = exp_q;
        endcase
    end

    always_comb begin
        mismatch_nxt = 1'b0;
        compl_nxt    = 1'b0;
        if (exp_valid) begin
            case (state)
                ST_SET, ST_RESET: begin
                    mismatch_nxt = (q != exp_q);
                    compl_nxt    = (q_bar == q);
                end
                ST_FORBID: mismatch_nxt = q | q_bar;
                default: begin
                    mismatch_nxt = 1'b0;
                    compl_nxt    = 1'b0;
                end
            endcase
        end
    end

    assign forbid_nxt = (sr == 2'b11) && (prev_sr != 2'b11);

    assign n_err   = {1'b0, mismatch_nxt} + {1'b0, compl_nxt} + {1'b0, forbid_nxt};
    assign cnt_sum = {2'b00, err_count} + SUM_W'(n_err);
    assign cnt_nxt = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_UNKNOWN;
            prev_sr      <= 2'b00;
            settle_cnt   <= SETTLE_INIT;
            exp_q        <= 1'b0;
            err_mismatch <= 1'b0;
            err_compl    <= 1'b0;
            err_forbid   <= 1'b0;
            err_sticky   <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_nxt;
            prev_sr      <= sr;
            exp_q        <= exp_q_nxt;
            err_mismatch <= mismatch_nxt;
            err_compl    <= compl_nxt;
            err_forbid   <= forbid_nxt;

            if (sr != prev_sr)
                settle_cnt <= SETTLE_INIT;
            else if (settle_cnt != '0)
                settle_cnt <= settle_cnt - 4'd1;

            // Pulses landing in the clear cycle still appear on the pulse outputs but are not counted.
            if (clr_err) begin
                err_sticky <= 1'b0;
                err_count  <= '0;
            end else begin
                err_sticky <= err_sticky | mismatch_nxt | compl_nxt | forbid_nxt;
                err_count  <= cnt_nxt;
            end
        end
    end

`ifdef SR_MON_COVER_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    logic enter_set;
    logic enter_reset;
    logic enter_forbid;
    logic hold_cyc;

    assign enter_set    = (state_nxt == ST_SET)    && (state != ST_SET);
    assign enter_reset  = (state_nxt == ST_RESET)  && (state != ST_RESET);
    assign enter_forbid = (state_nxt == ST_FORBID) && (state != ST_FORBID);
    assign hold_cyc     = (sr == 2'b00) && ((state == ST_SET) || (state == ST_RESET));

    always_ff @(posedge clk) begin
        if (!rst_n || clr_err) begin
            cov_set    <= '0;
            cov_reset  <= '0;
            cov_hold   <= '0;
            cov_forbid <= '0;
        end else begin
            cov_set    <= sat_inc(cov_set, enter_set);
            cov_reset  <= sat_inc(cov_reset, enter_reset);
            cov_hold   <= sat_inc(cov_hold, hold_cyc);
            cov_forbid <= sat_inc(cov_forbid, enter_forbid);
        end
    end
`endif

endmodule

// File: tb/tb_sr_latch_monitor.sv
// Table-driven scoreboard bench for sr_latch_monitor; a second instance with a 2-bit counter checks saturation.
module tb_sr_latch_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s = 1'b0;
    logic       r = 1'b0;
    logic       q = 1'b0;
    logic       q_bar = 1'b0;
    logic       clr_err = 1'b0;

    logic       exp_q, exp_valid, err_mismatch, err_compl, err_forbid, err_sticky;
    logic [7:0] err_count;
    logic       exp_q2, exp_valid2, err_mismatch2, err_compl2, err_forbid2, err_sticky2;
    logic [1:0] err_count2;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n, s, r, q, qb, clr;
        logic       eq, ev, em, ec, ef, es;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    sr_latch_monitor #(.SETTLE_CYC(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .q(q), .q_bar(q_bar), .clr_err(clr_err),
        .exp_q(exp_q), .exp_valid(exp_valid), .err_mismatch(err_mismatch), .err_compl(err_compl),
        .err_forbid(err_forbid), .err_sticky(err_sticky), .err_count(err_count)
    );

    sr_latch_monitor #(.SETTLE_CYC(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .q(q), .q_bar(q_bar), .clr_err(clr_err),
        .exp_q(exp_q2), .exp_valid(exp_valid2), .err_mismatch(err_mismatch2), .err_compl(err_compl2),
        .err_forbid(err_forbid2), .err_sticky(err_sticky2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic rn, input logic si, input logic ri, input logic qi,
                                input logic qbi, input logic ci, input logic eq, input logic ev,
                                input logic em, input logic ec, input logic ef, input logic es,
                                input int cnt, input int cnt2);
        vec_t v;
        v.rst_n = rn; v.s = si; v.r = ri; v.q = qi; v.qb = qbi; v.clr = ci;
        v.eq = eq; v.ev = ev; v.em = em; v.ec = ec; v.ef = ef; v.es = es;
        v.cnt = 8'(cnt); v.cnt2 = 2'(cnt2);
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL step %0d %s: got %0d expected %0d", idx, nm, act, expv);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rst_n = v.rst_n; s = v.s; r = v.r; q = v.q; q_bar = v.qb; clr_err = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("exp_q", idx, int'(exp_q), int'(e.eq));
        chk("exp_valid", idx, int'(exp_valid), int'(e.ev));
        chk("err_mismatch", idx, int'(err_mismatch), int'(e.em));
        chk("err_compl", idx, int'(err_compl), int'(e.ec));
        chk("err_forbid", idx, int'(err_forbid), int'(e.ef));
        chk("err_sticky", idx, int'(err_sticky), int'(e.es));
        chk("err_count", idx, int'(err_count), int'(e.cnt));
        chk("err_count_w2", idx, int'(err_count2), int'(e.cnt2));
    endtask

    initial begin
        //             rst s r q qb clr | eq ev em ec ef es cnt cnt2
        tbl.push_back(mk(0, 0,0, 0,0, 0,  0, 0, 0, 0, 0, 0, 0, 0));  // 0 reset
        tbl.push_back(mk(1, 1,0, 1,0, 0,  1, 0, 0, 0, 0, 0, 0, 0));  // 1 set
        tbl.push_back(mk(1, 1,0, 1,0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1,0, 1,0, 0,  1, 1, 0, 0, 0, 0, 0, 0));  // 3 settled
        tbl.push_back(mk(1, 1,0, 1,0, 0,  1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0,0, 1,0, 0,  1, 0, 0, 0, 0, 0, 0, 0));  // 5 hold
        tbl.push_back(mk(1, 0,0, 1,0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0,0, 1,0, 0,  1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0,0, 1,0, 0,  1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0,0, 1,0, 0,  1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0,1, 1,0, 0,  0, 0, 0, 0, 0, 0, 0, 0));  // 10 reset, q stuck at 1
        tbl.push_back(mk(1, 0,1, 1,0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0,1, 1,0, 0,  0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0,1, 1,0, 0,  0, 1, 1, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 0,1, 1,0, 0,  0, 1, 1, 0, 0, 1, 2, 2));
        tbl.push_back(mk(1, 0,1, 1,0, 0,  0, 1, 1, 0, 0, 1, 3, 3));
        tbl.push_back(mk(1, 1,1, 0,1, 0,  0, 0, 0, 0, 1, 1, 4, 3));  // 16 forbid entry
        tbl.push_back(mk(1, 1,1, 0,0, 0,  0, 0, 0, 0, 0, 1, 4, 3));
        tbl.push_back(mk(1, 1,1, 0,0, 0,  0, 1, 0, 0, 0, 1, 4, 3));
        tbl.push_back(mk(1, 1,1, 0,0, 0,  0, 1, 0, 0, 0, 1, 4, 3));
        tbl.push_back(mk(1, 0,0, 0,0, 0,  0, 0, 0, 0, 0, 1, 4, 3));  // 20 unknown
        tbl.push_back(mk(1, 0,0, 0,0, 0,  0, 0, 0, 0, 0, 1, 4, 3));
        tbl.push_back(mk(1, 0,0, 0,0, 0,  0, 0, 0, 0, 0, 1, 4, 3));
        tbl.push_back(mk(1, 0,0, 0,0, 0,  0, 0, 0, 0, 0, 1, 4, 3));
        tbl.push_back(mk(1, 0,1, 0,1, 0,  0, 0, 0, 0, 0, 1, 4, 3));  // 24 reset
        tbl.push_back(mk(1, 0,1, 0,1, 0,  0, 0, 0, 0, 0, 1, 4, 3));
        tbl.push_back(mk(1, 0,1, 0,1, 0,  0, 1, 0, 0, 0, 1, 4, 3));
        tbl.push_back(mk(1, 0,1, 0,0, 0,  0, 1, 0, 1, 0, 1, 5, 3));  // 27 q_bar stuck low
        tbl.push_back(mk(1, 0,1, 0,0, 0,  0, 1, 0, 1, 0, 1, 6, 3));
        tbl.push_back(mk(1, 0,1, 0,0, 1,  0, 1, 0, 1, 0, 0, 0, 0));  // 29 clear
        tbl.push_back(mk(1, 0,1, 0,1, 0,  0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0,1, 1,1, 0,  0, 1, 1, 1, 0, 1, 2, 2));  // 31 double error
        tbl.push_back(mk(1, 0,1, 1,1, 0,  0, 1, 1, 1, 0, 1, 4, 3));
        tbl.push_back(mk(1, 1,0, 0,1, 0,  1, 0, 0, 0, 0, 1, 4, 3));  // 33 toggling
        tbl.push_back(mk(1, 0,0, 1,0, 0,  1, 0, 0, 0, 0, 1, 4, 3));
        tbl.push_back(mk(1, 1,0, 1,0, 0,  1, 0, 0, 0, 0, 1, 4, 3));
        tbl.push_back(mk(1, 0,0, 1,0, 0,  1, 0, 0, 0, 0, 1, 4, 3));
        tbl.push_back(mk(1, 1,0, 1,0, 0,  1, 0, 0, 0, 0, 1, 4, 3));
        tbl.push_back(mk(0, 1,1, 1,1, 0,  0, 0, 0, 0, 0, 0, 0, 0));  // 38 reset beats forbid pulse
        tbl.push_back(mk(1, 0,0, 0,0, 0,  0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // Settle restart: wrong outputs during a partially settled window are never checked.
        apply(mk(1, 1,0, 0,0, 0,  1, 0, 0, 0, 0, 0, 0, 0), 100);
        apply(mk(1, 1,0, 0,0, 0,  1, 0, 0, 0, 0, 0, 0, 0), 101);
        apply(mk(1, 0,1, 0,0, 0,  0, 0, 0, 0, 0, 0, 0, 0), 102);
        apply(mk(1, 0,1, 0,1, 0,  0, 0, 0, 0, 0, 0, 0, 0), 103);
        apply(mk(1, 0,1, 0,1, 0,  0, 1, 0, 0, 0, 0, 0, 0), 104);
        apply(mk(1, 0,1, 0,1, 0,  0, 1, 0, 0, 0, 0, 0, 0), 105);

        // Forbid straight out of reset pulses once, then stays quiet.
        apply(mk(0, 0,0, 0,0, 0,  0, 0, 0, 0, 0, 0, 0, 0), 110);
        apply(mk(1, 1,1, 0,0, 0,  0, 0, 0, 0, 1, 1, 1, 1), 111);
        apply(mk(1, 1,1, 0,0, 0,  0, 0, 0, 0, 0, 1, 1, 1), 112);
        apply(mk(1, 1,1, 0,0, 0,  0, 1, 0, 0, 0, 1, 1, 1), 113);
        apply(mk(1, 1,1, 1,0, 0,  0, 1, 1, 0, 0, 1, 2, 2), 114);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
